// File: rtl/uart_pkg.sv
// Shared UART transmitter types and constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_unit_if.sv
// Store-to-UART interface: the core (master) writes and starts frames, the transmitter (slave) responds.
interface uart_tx_unit_if;

    logic [7:0] data_to_uart;
    logic       load_uart;
    logic       transfer_byte;
    logic       uart_tx;
    logic       uart_busy;
    logic       uart_done;

    modport master (
        output data_to_uart,
        output load_uart,
        output transfer_byte,
        input  uart_tx,
        input  uart_busy,
        input  uart_done
    );

    modport slave (
        input  data_to_uart,
        input  load_uart,
        input  transfer_byte,
        output uart_tx,
        output uart_busy,
        output uart_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter, 8 data bits LSB first, one stop bit.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_unit_if.slave  bus
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     holding_q, holding_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tick;
    logic [7:0]     frame_byte;
`ifdef UART_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q != IDLE),
        .tick_o(tick)
    );

    // A load in the same cycle as the start bypasses the holding register.
    assign frame_byte = bus.load_uart ? bus.data_to_uart : holding_q;

    always_comb begin
        state_d   = state_q;
        holding_d = holding_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (bus.load_uart && !busy_q) begin
            holding_d = bus.data_to_uart;
        end

        case (state_q)
            IDLE: begin
                tx_d   = UART_IDLE_LEVEL;
                busy_d = 1'b0;
                if (bus.transfer_byte) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    shift_d  = frame_byte;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^frame_byte;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            holding_q <= 8'h00;
            shift_q   <= 8'h00;
            idx_q     <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            holding_q <= holding_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.uart_tx   = tx_q;
    assign bus.uart_busy = busy_q;
    assign bus.uart_done = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit with a bit-slot reference model (CLKS_PER_BIT = 4).
module tb_uart_tx_unit;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int NBITS = 11;
`else
    localparam bit PAR   = 1'b0;
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    uart_tx_unit_if bus ();

    uart_tx_unit #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level k cycles after the start edge: slot 0 start, 1..8 data LSB first,
    // optional even parity, then stop.
    function automatic logic line_level(input logic [7:0] b, input int k);
        int slot;
        slot = (k - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic start_frame(input bit do_load, input logic [7:0] d);
        @(negedge clk);
        bus.data_to_uart  = d;
        bus.load_uart     = do_load;
        bus.transfer_byte = 1'b1;
    endtask

    task automatic load_only(input logic [7:0] d);
        @(negedge clk);
        bus.data_to_uart  = d;
        bus.load_uart     = 1'b1;
        bus.transfer_byte = 1'b0;
        @(negedge clk);
        bus.load_uart     = 1'b0;
    endtask

    // Walks one frame whose start was sampled at the previous edge; optionally pokes
    // load+transfer mid-frame and/or chains a new transfer on the done cycle.
    task automatic run_frame(input logic [7:0] b, input bit chain, input int poke_k,
                             input logic [7:0] poke_d);
        logic [2:0] got;
        logic [2:0] exp;
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            bus.load_uart     = 1'b0;
            bus.transfer_byte = 1'b0;
            exp = (k <= FL) ? {line_level(b, k), 1'b1, 1'b0} : 3'b101;
            got = {bus.uart_tx, bus.uart_busy, bus.uart_done};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL frame_%02h cycle %0d: tx/busy/done = %b, expected %b", b, k, got, exp);
            end
            if (k == poke_k) begin
                bus.data_to_uart  = poke_d;
                bus.load_uart     = 1'b1;
                bus.transfer_byte = 1'b1;
            end
            if (k == FL + 1 && chain) bus.transfer_byte = 1'b1;
        end
        if (!chain) begin
            @(negedge clk);
            got = {bus.uart_tx, bus.uart_busy, bus.uart_done};
            n_checks++;
            if (got !== 3'b100) begin
                n_fail++;
                $display("FAIL post_frame_%02h: tx/busy/done = %b, expected 100", b, got);
            end
        end
        $display("frame %02h checked over %0d cycles", b, FL + 1);
    endtask

    task automatic test_reset;
        logic [2:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {bus.uart_tx, bus.uart_busy, bus.uart_done};
        n_checks++;
        if (got !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_value: tx/busy/done = %b, expected 100", got);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = {bus.uart_tx, bus.uart_busy, bus.uart_done};
            n_checks++;
            if (got !== 3'b100) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: tx/busy/done = %b, expected 100", i, got);
            end
        end
        $display("reset/idle checked");
    endtask

    task automatic test_basic;
        load_only(8'hA5);
        start_frame(1'b0, 8'h00);
        run_frame(8'hA5, 1'b0, 0, 8'h00);
    endtask

    task automatic test_bypass;
        load_only(8'hFF);
        start_frame(1'b1, 8'h3C);
        run_frame(8'h3C, 1'b0, 15, 8'h00);
        // Mid-frame load must not have replaced the holding register.
        start_frame(1'b0, 8'h00);
        run_frame(8'h3C, 1'b0, 0, 8'h00);
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        load_only(b);
        start_frame(1'b0, 8'h00);
        run_frame(b, 1'b1, 0, 8'h00);
        run_frame(b, 1'b0, 0, 8'h00);
    endtask

    task automatic test_reset_mid_frame;
        logic [1:0] got;
        load_only(8'h5A);
        start_frame(1'b0, 8'h00);
        @(negedge clk);
        bus.transfer_byte = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 got = {bus.uart_tx, bus.uart_busy};
        n_checks++;
        if (got !== 2'b10) begin
            n_fail++;
            $display("FAIL async_reset: tx/busy = %b, expected 10", got);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Holding register was cleared by reset.
        start_frame(1'b0, 8'h00);
        run_frame(8'h00, 1'b0, 0, 8'h00);
        load_only(8'h81);
        start_frame(1'b0, 8'h00);
        run_frame(8'h81, 1'b0, 0, 8'h00);
    endtask

    task automatic test_parity_bytes;
        start_frame(1'b1, 8'h07);
        run_frame(8'h07, 1'b0, 0, 8'h00);
        start_frame(1'b1, 8'h03);
        run_frame(8'h03, 1'b0, 0, 8'h00);
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                start_frame(1'b1, b);
            end else begin
                load_only(b);
                start_frame(1'b0, 8'h00);
            end
            run_frame(b, 1'b0, (i % 2 == 0) ? int'($urandom_range(2, FL - 1)) : 0,
                      8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.data_to_uart  = 8'h00;
        bus.load_uart     = 1'b0;
        bus.transfer_byte = 1'b0;
        test_reset();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity_bytes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
